// File: rtl/mult_arb_pkg.sv
// Shared defaults and helpers for the multiplier arbiter slice.
package mult_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAG_DEPTH = 8;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_TAG_W = tag_width(DEF_N_REQ);

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding the requester index of every in-flight multiply.
module tag_fifo
  import mult_arb_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH,
  parameter int W     = DEF_TAG_W
) (
  input  logic                       clk,
  input  logic                       sclr_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = tag_width(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one in-order pipelined multiplier among N_REQ requesters.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                    clk,
  input  logic                    sclr_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    mult_sclr,
  output logic                    mult_nd,
  output logic [DATA_W-1:0]       mult_a,
  output logic [DATA_W-1:0]       mult_b,
  input  logic                    mult_rfd,
  input  logic                    mult_rdy,
  input  logic [DATA_W-1:0]       mult_result,
  output logic                    busy,
  output logic                    err
);

  localparam int TAG_W = tag_width(N_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  gnt_idx;
  logic [TAG_W-1:0]  cand;
  logic              gnt_any;

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;

  logic [N_REQ-1:0]  rsp_vld_p1;
  logic [DATA_W-1:0] rsp_res_p1;
  logic              err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [TAG_W-1:0]  fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              rsp_pop;

  // Stage p0: combinational round-robin grant starting at rr_ptr
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (sclr_n && mult_rfd && !fifo_full) begin
      for (int i = 0; i < N_REQ; i++) begin
        cand = TAG_W'((int'(rr_ptr) + i) % N_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Stage p1: issue register toward the multiplier
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      rr_ptr <= '0;
    end else begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        a_p1   <= req_a[int'(gnt_idx)*DATA_W +: DATA_W];
        b_p1   <= req_b[int'(gnt_idx)*DATA_W +: DATA_W];
        rr_ptr <= TAG_W'(rr_next(int'(gnt_idx), N_REQ));
      end
    end
  end

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk    (clk),
    .sclr_n (sclr_n),
    .push   (gnt_any),
    .din    (gnt_idx),
    .pop    (rsp_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign rsp_pop = mult_rdy && !fifo_empty;

  // Stage p1 (return path): route the result to the tag at the FIFO head
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      rsp_vld_p1 <= '0;
      rsp_res_p1 <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_vld_p1 <= '0;
      if (rsp_pop) begin
        rsp_vld_p1[fifo_dout] <= 1'b1;
        rsp_res_p1            <= mult_result;
      end
      if (mult_rdy && fifo_empty) err_q <= 1'b1;
    end
  end

  assign mult_sclr  = ~sclr_n;
  assign mult_nd    = vld_p1;
  assign mult_a     = a_p1;
  assign mult_b     = b_p1;
  assign rsp_valid  = rsp_vld_p1;
  assign rsp_result = rsp_res_p1;
  assign busy       = (fifo_count != '0) || vld_p1;
  assign err        = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: queue-based reference model plus directed literal checks.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TD = 8;

  logic            clk = 1'b0;
  logic            sclr_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_result;
  logic            mult_sclr;
  logic            mult_nd;
  logic [DW-1:0]   mult_a;
  logic [DW-1:0]   mult_b;
  logic            mult_rfd;
  logic            mult_rdy;
  logic [DW-1:0]   mult_result;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clk         (clk),
    .sclr_n      (sclr_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .mult_sclr   (mult_sclr),
    .mult_nd     (mult_nd),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_rfd    (mult_rfd),
    .mult_rdy    (mult_rdy),
    .mult_result (mult_result),
    .busy        (busy),
    .err         (err)
  );

  // Reference model state: in-flight tags in issue order, rotating priority start.
  int          m_ptr;
  int          m_tags[$];
  bit          m_nd;
  logic [31:0] m_a, m_b, m_rsp_res;
  int          m_rsp_tag;
  bit          m_err, m_rst, started;
  int          n_chk, n_fail;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (!sclr_n || !mult_rfd || m_tags.size() >= TD) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    if (!sclr_n) begin
      m_ptr = 0; m_tags.delete(); m_nd = 0; m_a = '0; m_b = '0;
      m_rsp_tag = -1; m_rsp_res = '0; m_err = 0; m_rst = 1; started = 1;
    end else begin
      g = exp_grant();
      m_rst = 0;
      m_rsp_tag = -1;
      if (mult_rdy) begin
        if (m_tags.size() > 0) begin
          m_rsp_tag = m_tags.pop_front();
          m_rsp_res = mult_result;
        end else begin
          m_err = 1;
        end
      end
      if (g >= 0) begin
        m_tags.push_back(g);
        m_ptr = (g + 1) % N;
        m_nd  = 1;
        m_a   = req_a[g*DW +: DW];
        m_b   = req_b[g*DW +: DW];
      end else begin
        m_nd = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_rdy, exp_rsp;
    int g;
    if (!started) return;
    exp_rdy = '0;
    g = exp_grant();
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rsp = '0;
    if (m_rsp_tag >= 0) exp_rsp[m_rsp_tag] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_rsp);
    if (m_rsp_tag >= 0 || m_rst) check("rsp_result", rsp_result, m_rsp_res);
    check("mult_nd", mult_nd, m_nd);
    if (m_nd || m_rst) begin
      check("mult_a", mult_a, m_a);
      check("mult_b", mult_b, m_b);
    end
    check("busy", busy, (m_tags.size() != 0) || m_nd);
    check("err", err, m_err);
    check("mult_sclr", mult_sclr, !sclr_n);
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    sclr_n = 1'b0; req_valid = '0; mult_rdy = 1'b0;
    cyc();
    sclr_n = 1'b1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = 32'h1000_0000 * (i + 1) + 32'h11;
      req_b[i*DW +: DW] = 32'h0100_0000 * (i + 1) + 32'h22;
    end
  endtask

  logic [N-1:0] got_rr [6];
  logic [N-1:0] exp_rr [6];
  int n_g;

  initial begin
    n_chk = 0; n_fail = 0; started = 0; m_rsp_tag = -1; m_ptr = 0;
    m_nd = 0; m_err = 0; m_rst = 0; m_a = '0; m_b = '0; m_rsp_res = '0;
    sclr_n = 1'b0; req_valid = '1; mult_rfd = 1'b1; mult_rdy = 1'b0;
    mult_result = '0; set_ops();
    #1;
    cyc(); cyc();
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mult_nd", mult_nd, 0);
    check("rst_mult_sclr", mult_sclr, 1);

    // Single operation 2.0 * 3.0
    sclr_n = 1'b1; req_valid = 4'b0001;
    req_a[31:0] = 32'h4000_0000; req_b[31:0] = 32'h4040_0000;
    cyc();
    check("single_nd", mult_nd, 1);
    check("single_a", mult_a, 32'h4000_0000);
    check("single_b", mult_b, 32'h4040_0000);
    req_valid = '0;
    cyc();
    check("single_nd_drop", mult_nd, 0);
    check("single_busy", busy, 1);
    mult_rdy = 1'b1; mult_result = 32'h40C0_0000;
    cyc();
    check("single_rsp_valid", rsp_valid, 4'b0001);
    check("single_rsp_result", rsp_result, 32'h40C0_0000);
    mult_rdy = 1'b0;
    cyc();
    check("single_rsp_clear", rsp_valid, 4'b0000);
    check("single_idle", busy, 0);

    // Round-robin order with all requesters active
    set_ops(); do_reset(); req_valid = '1;
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int k = 0; k < 6; k++) begin
      #1; got_rr[k] = req_ready;
      cyc();
    end
    for (int k = 0; k < 6; k++) check("rr_order", got_rr[k], exp_rr[k]);

    // Fill the tag FIFO, then free one slot
    do_reset(); req_valid = '1; n_g = 0;
    for (int k = 0; k < 12; k++) begin
      #1; if (req_ready != '0) n_g++;
      cyc();
    end
    check("full_grant_count", n_g, 8);
    mult_rdy = 1'b1; mult_result = 32'h3F80_0000;
    #1; check("full_pop_cycle_ready", req_ready, 4'b0000);
    cyc();
    mult_rdy = 1'b0;
    check("full_pop_rsp", rsp_valid, 4'b0001);
    check("full_after_pop_ready", req_ready, 4'b0001);
    cyc();
    check("full_again_ready", req_ready, 4'b0000);

    // Simultaneous push and pop at occupancy 3
    do_reset(); req_valid = 4'b0111;
    cyc(); cyc(); cyc();
    req_valid = 4'b1000; mult_rdy = 1'b1; mult_result = 32'hA1;
    cyc();
    check("pp_occupancy_model", m_tags.size(), 3);
    check("pp_rsp", rsp_valid, 4'b0001);
    check("pp_result", rsp_result, 32'hA1);
    check("pp_issue_a", mult_a, req_a[3*DW +: DW]);
    req_valid = '0; mult_result = 32'hA2;
    cyc();
    check("pp_drain1", rsp_valid, 4'b0010);
    mult_result = 32'hA3;
    cyc();
    check("pp_drain2", rsp_valid, 4'b0100);
    check("pp_busy2", busy, 1);
    mult_result = 32'hA4;
    cyc();
    check("pp_drain3", rsp_valid, 4'b1000);
    check("pp_result3", rsp_result, 32'hA4);
    check("pp_idle", busy, 0);
    mult_rdy = 1'b0;

    // Reset with four operations in flight
    do_reset(); req_valid = '1;
    cyc(); cyc(); cyc(); cyc();
    req_valid = '0; sclr_n = 1'b0;
    cyc();
    check("mid_rst_rsp", rsp_valid, 4'b0000);
    check("mid_rst_result", rsp_result, 32'h0);
    check("mid_rst_nd", mult_nd, 0);
    check("mid_rst_a", mult_a, 32'h0);
    check("mid_rst_busy", busy, 0);
    sclr_n = 1'b1; mult_rdy = 1'b1;
    cyc(); check("dropped_rsp1", rsp_valid, 4'b0000);
    cyc(); check("dropped_rsp2", rsp_valid, 4'b0000);
    mult_rdy = 1'b0;

    // Spurious mult_rdy with empty FIFO
    do_reset();
    check("err_cleared", err, 0);
    mult_rdy = 1'b1;
    cyc();
    check("spurious_err", err, 1);
    check("spurious_rsp", rsp_valid, 4'b0000);
    mult_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); check("err_sticky", err, 1);
    end
    do_reset();
    check("err_reset", err, 0);

    // Mixed traffic checked cycle by cycle against the model
    for (int k = 0; k < 400; k++) begin
      sclr_n      = ($urandom_range(0, 63) != 0);
      req_valid   = N'($urandom);
      mult_rfd    = ($urandom_range(0, 3) != 0);
      mult_rdy    = ($urandom_range(0, 2) == 0);
      mult_result = $urandom;
      for (int i = 0; i < N; i++) begin
        req_a[i*DW +: DW] = $urandom;
        req_b[i*DW +: DW] = $urandom;
      end
      cyc();
    end
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the multiplier.
REQ-002 Parameter DATA_W, default 32, IEEE-754 single operand/result width.
REQ-003 Parameter TAG_DEPTH, default 8, in-flight tag FIFO depth; SHALL be >= multiplier latency for full throughput.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 sclr_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  N_REQ  per-requester operation request.
REQ-007 req_a, req_b  in  N_REQ*DATA_W  packed operands, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  out  N_REQ  one-hot, one-cycle result strobe to the owning requester.
REQ-010 rsp_result  out  DATA_W  shared result bus, valid when any rsp_valid bit is high.
REQ-011 mult_sclr  out  1  multiplier clear, active-high, equal to ~sclr_n.
REQ-012 mult_nd, mult_a, mult_b  out  1/DATA_W/DATA_W  multiplier new-data strobe and operands.
REQ-013 mult_rfd, mult_rdy, mult_result  in  1/1/DATA_W  multiplier ready-for-data, result-valid, result.
REQ-014 busy  out  1  high while any operation is in flight.
REQ-015 err  out  1  sticky: mult_rdy seen with empty tag FIFO.

Function
REQ-016 Grant SHALL be issued only when mult_rfd is high and the tag FIFO is not full.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer p; after a grant to i, p becomes (i+1) mod N_REQ; p is unchanged in cycles without a grant.
REQ-018 req_ready SHALL be combinational, at most one bit high, and only for a requester with req_valid high.
REQ-019 On a transfer, mult_a/mult_b SHALL be registered from the granted operands and mult_nd SHALL pulse high for exactly the next cycle; issue latency 1 cycle.
REQ-020 The granted index (TAG_W = clog2(N_REQ) bits) SHALL be pushed into the tag FIFO in the transfer cycle.
REQ-021 Throughput SHALL be one issue per cycle while conditions of REQ-016 hold.
REQ-022 On mult_rdy high, the FIFO head SHALL be popped; the next cycle rsp_valid[head]=1 and rsp_result=mult_result (registered, latency 1).
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and both SHALL take effect.
REQ-024 Full FIFO: no grant; the pop in the same cycle does not free a slot until the following cycle.
REQ-025 mult_rdy with empty FIFO: no rsp_valid, err set and held until reset.
REQ-026 busy SHALL equal (FIFO occupancy != 0) or mult_nd.
REQ-027 Results SHALL be returned strictly in issue order; the multiplier is in-order.

Reset
REQ-028 With sclr_n low at a clock edge: req_ready=0, rsp_valid=0, rsp_result=0, mult_nd=0, mult_a=mult_b=0, busy=0, err=0, p=0, FIFO empty.
REQ-029 Reset mid-operation SHALL drop all in-flight operations; no rsp_valid SHALL be produced for them, and mult_sclr flushes the multiplier.

Structure
REQ-030 Package mult_arb_pkg SHALL hold N_REQ, DATA_W, TAG_DEPTH defaults and derived TAG_W.
REQ-031 The tag FIFO SHALL be a sub-module tag_fifo (sync, push/pop/full/empty/count, same reset).
REQ-032 Arbiter, issue register and response register SHALL reside in mult_arbiter.

Verification
REQ-033 Single op: req 0 with a=0x40000000 (2.0), b=0x40400000 (3.0) -> mult_nd one cycle after grant; after mult_rdy, rsp_valid[0] high and rsp_result=0x40C00000 (6.0).
REQ-034 Round-robin: all four req_valid held high, mult_rfd=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles.
REQ-035 Full: mult_rdy held low, TAG_DEPTH=8 -> exactly 8 grants, then req_ready=0 until the first mult_rdy, one grant on the cycle after it.
REQ-036 Push/pop together: occupancy 3, grant and mult_rdy in the same cycle -> occupancy stays 3, correct tag routed.
REQ-037 Reset with 4 ops in flight -> all outputs zero, no rsp_valid afterwards for dropped ops, busy=0.
REQ-038 Spurious mult_rdy with empty FIFO -> err=1 held, no rsp_valid.
